// File: rtl/regfile_fifo_ctrl_if.sv
// regfile_fifo_ctrl_if: write/read port bundle between the queue controller and the register file
interface regfile_fifo_ctrl_if #(parameter int DATA_W = 4, parameter int ADDR_W = 3);
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_ra;
  logic [DATA_W-1:0] rf_rd;
  modport master (output rf_wa, rf_wd, rf_we, rf_ra, input rf_rd);
  modport slave  (input rf_wa, rf_wd, rf_we, rf_ra, output rf_rd);
endinterface

// File: rtl/regfile_fifo_ctrl.sv
// regfile_fifo_ctrl: circular-queue controller driving an external 2R/1W register file
module regfile_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enq,
  input  logic [DATA_W-1:0] din,
  input  logic              deq,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  regfile_fifo_ctrl_if.master rf
);
  logic [ADDR_W-1:0] head, tail;
  logic enq_ok, deq_ok;
  assign full   = count == (ADDR_W+1)'(2**ADDR_W);
  assign empty  = count == '0;
  assign deq_ok = deq & ~empty;
  // a full queue still accepts a write when the same slot is being read out
  assign enq_ok = enq & (~full | deq_ok);
  assign rf.rf_ra = head;
  assign rf.rf_wa = tail;
  assign rf.rf_wd = din;
  assign rf.rf_we = rstn & enq_ok;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      tail       <= enq_ok ? tail + 1'b1 : tail;
      head       <= deq_ok ? head + 1'b1 : head;
      dout       <= deq_ok ? rf.rf_rd : dout;
      dout_valid <= deq_ok;
      count      <= (enq_ok && !deq_ok) ? count + 1'b1 : (deq_ok && !enq_ok) ? count - 1'b1 : count;
      ovf        <= enq & full & ~deq_ok;
      udf        <= deq & empty;
    end
endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// tb_regfile_fifo_ctrl: directed stimulus with a dout scoreboard; the bench models the register file
module tb_regfile_fifo_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enq = 1'b0;
  logic deq = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] dout;
  logic dout_valid, full, empty, ovf, udf;
  logic [3:0] count;
  logic [3:0] mem [8];
  int errors = 0;
  int checks = 0;
  int exp_q [$];

  regfile_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) rf ();

  regfile_fifo_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (
    .clk(clk), .rstn(rstn), .enq(enq), .din(din), .deq(deq),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf), .rf(rf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf.rf_we) mem[rf.rf_wa] <= rf.rf_wd;
  assign rf.rf_rd = mem[rf.rf_ra];

  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, want, $time);
    end
  endtask

  // scoreboard monitor: every dout_valid pulse must match the oldest expected word
  always @(negedge clk) if (rstn && dout_valid) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL dout_unexpected: got %0d expected no output at %0t", dout, $time);
    end else begin
      int w;
      w = exp_q.pop_front();
      if (int'(dout) != w) begin
        errors++;
        $display("FAIL dout: got %0d expected %0d at %0t", dout, w, $time);
      end
    end
  end

  task automatic drive(input logic e, input logic [3:0] d, input logic q);
    enq = e; din = d; deq = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    #2 enq = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_we", rf.rf_we, 0);
    chk("rst_ra", rf.rf_ra, 0);
    chk("rst_wa", rf.rf_wa, 0);
    enq = 1'b0;
    #9 rstn = 1'b1;
    tick();
    chk("idle_count", count, 0);
    // fill to full
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i + 1), 0);
      chk("fill_we", rf.rf_we, 1);
      chk("fill_wa", rf.rf_wa, i);
      tick();
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    drive(1, 4'd9, 0);
    chk("ovf_we", rf.rf_we, 0);
    tick();
    chk("ovf_pulse", ovf, 1);
    chk("ovf_count", count, 8);
    tick();
    chk("ovf_clear", ovf, 0);
    // drain
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i + 1);
      drive(0, 0, 1);
      chk("drain_ra", rf.rf_ra, i);
      tick();
    end
    chk("drain_empty", empty, 1);
    drive(0, 0, 1);
    tick();
    chk("udf_pulse", udf, 1);
    chk("udf_dout", dout, 8);
    chk("udf_valid", dout_valid, 0);
    tick();
    chk("udf_clear", udf, 0);
    // wrap: 5 in, 5 out, 6 in spanning address 7 -> 0
    for (int i = 0; i < 5; i++) begin drive(1, 4'(i + 1), 0); tick(); end
    for (int i = 0; i < 5; i++) begin exp_q.push_back(i + 1); drive(0, 0, 1); tick(); end
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'(10 + i), 0);
      chk("wrap_wa", rf.rf_wa, (5 + i) % 8);
      tick();
    end
    for (int i = 0; i < 6; i++) begin exp_q.push_back(10 + i); drive(0, 0, 1); tick(); end
    chk("wrap_empty", empty, 1);
    // simultaneous on empty: enqueue wins, dequeue underflows
    drive(1, 4'd7, 1);
    tick();
    chk("sim_empty_count", count, 1);
    chk("sim_empty_udf", udf, 1);
    for (int i = 0; i < 3; i++) begin drive(1, 4'(8 + i), 0); tick(); end
    chk("half_count", count, 4);
    exp_q.push_back(7);
    drive(1, 4'd11, 1);
    tick();
    chk("sim_half_count", count, 4);
    for (int i = 0; i < 4; i++) begin drive(1, 4'(12 + i), 0); tick(); end
    chk("sim_full_pre", full, 1);
    exp_q.push_back(8);
    drive(1, 4'd5, 1);
    chk("sim_full_we", rf.rf_we, 1);
    tick();
    chk("sim_full_count", count, 8);
    chk("sim_full_ovf", ovf, 0);
    for (int i = 0; i < 7; i++) begin exp_q.push_back(9 + i); drive(0, 0, 1); tick(); end
    exp_q.push_back(5);
    drive(0, 0, 1);
    tick();
    chk("sim_full_drained", count, 0);
    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin drive(1, 4'(i + 1), 0); tick(); end
    chk("pre_rst_count", count, 5);
    rstn = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    #2 rstn = 1'b1;
    drive(0, 0, 1);
    tick();
    chk("post_rst_udf", udf, 1);
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/regfile_fifo_ctrl.md
Name: regfile_fifo_ctrl

Overview:
- Circular-queue controller that drives an external 2-port-read/1-port-write register file (depth 2**ADDR_W, width DATA_W, synchronous write, combinational read).
- Maintains head/tail pointers and an occupancy count, and generates the write port (address, data, enable) plus one read address.
- Presents the dequeued word on a registered output with a one-cycle valid pulse.
- Forms the client side of the register-file interface in the lab datapath.

Parameters:
- DATA_W, 4, data word width; must match the register file's data width.
- ADDR_W, 3, register-file address width; queue depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- enq  in  1  enqueue request, sampled every rising edge.
- din  in  DATA_W  enqueue data.
- deq  in  1  dequeue request, sampled every rising edge.
- dout  out  DATA_W  last dequeued word (registered).
- dout_valid  out  1  one-cycle pulse; dout updated this cycle.
- full  out  1  count == 2**ADDR_W.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  current occupancy.
- ovf  out  1  one-cycle pulse; enq rejected because queue full.
- udf  out  1  one-cycle pulse; deq rejected because queue empty.
- rf_wa  out  ADDR_W  register-file write address.
- rf_wd  out  DATA_W  register-file write data.
- rf_we  out  1  register-file write enable.
- rf_ra  out  ADDR_W  register-file read address.
- rf_rd  in  DATA_W  register-file read data (combinational from rf_ra).

Behaviour:
- Reset (rstn low, asynchronous, regardless of clk):
  - head=0, tail=0, count=0, dout=0, dout_valid=0, ovf=0, udf=0.
  - rf_we is forced 0 while rstn is low. Register-file contents are not cleared.
- Combinational outputs:
  - rf_ra=head, rf_wa=tail, rf_wd=din.
  - rf_we = enq_ok, where enq_ok = enq & (~full | deq_ok) and deq_ok = deq & ~empty.
  - full and empty are decoded from count.
- On every rising edge with rstn high:
  - If enq_ok: the register file captures din at tail; tail <= tail+1, wrapping modulo 2**ADDR_W.
  - If deq_ok: dout <= rf_rd (word at head before the edge); head <= head+1 (wrapping); dout_valid <= 1. Otherwise dout_valid <= 0 and dout holds its value.
  - count: +1 if enq_ok only; -1 if deq_ok only; unchanged if both or neither.
  - ovf <= enq & full & ~deq_ok.
  - udf <= deq & empty.
- Latency:
  - A word enqueued at edge N is readable via deq at edge N+1 at the earliest.
  - dout and dout_valid appear the cycle after the deq edge.
- Simultaneous enq and deq:
  - Empty: the enqueue is accepted, the dequeue is rejected (udf=1, no bypass). count becomes 1.
  - Full: both are accepted. tail==head, so the old word is read and the new word is written into the same slot at the same edge. count stays 2**ADDR_W; ovf=0.
  - Otherwise: both are accepted, count unchanged.
- Wrap-around: pointers are ADDR_W bits wide and roll over naturally. full/empty come from count only, never from pointer comparison.
- A rejected request changes no state except the ovf/udf pulse.
- Requests held high for multiple cycles act once per cycle; there is no edge detection.
- Reset asserted mid-stream empties the queue immediately. Stale register-file data is never presented, because empty blocks deq.

Test Plan:
- Reset, then idle: count=0, empty=1, full=0, dout=0, dout_valid=0, rf_we=0, rf_ra=0, rf_wa=0.
- Enqueue 8 words 1..8 on consecutive cycles (ADDR_W=3): rf_we high each cycle with rf_wa=0..7, count=8, full=1. A 9th enq (value 9) gives ovf=1 for one cycle, count stays 8, rf_we=0.
- From full, dequeue 8 times: dout=1..8 in order, dout_valid high on each following cycle, empty=1 at end. A further deq gives udf=1, dout stays 8.
- Wrap: enq 5, deq 5, enq 6 (values A..F): rf_wa wraps 7->0, and the dequeues return the values in enqueue order.
- Simultaneous enq/deq:
  - Empty: count becomes 1 and udf pulses.
  - Half full (count=4): count stays 4, the oldest word is output.
  - Full: count stays 8, dout = oldest word, and a later drain returns the new word last.
- Assert rstn low for less than one clk period mid-stream with count=5: count=0, empty=1 immediately (asynchronously), and the next deq gives udf=1.
